sipo_deserializer: RTL and testbench

Serial-to-parallel receiver. It is the receive end of the serial stream produced by the team's load-and-shift register.
- Collects N serial bits, each qualified by a bit strobe, into a word.
- Holds the completed word in a one-entry output buffer with a valid/ready handshake.
- Flags overrun when a word completes while the buffer is still occupied.
- Sits between the serial link pins and the parallel datapath consumer.

---
 rtl/sipo_deserializer_pkg.sv | 13 +
 rtl/sipo_out_buf.sv | 47 ++++
 rtl/sipo_deserializer.sv | 82 ++++++++
 tb/tb_sipo_deserializer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_deserializer_pkg.sv
// Shared types and helpers for the serial-to-parallel receiver.
package sipo_deserializer_pkg;

   typedef logic [0:0] state_t;

   localparam state_t IDLE  = 1'b0;
   localparam state_t SHIFT = 1'b1;

   function automatic int unsigned cnt_width(input int unsigned n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/sipo_out_buf.sv
// One-entry valid/ready holding register with sticky overrun detection.
module sipo_out_buf
   import sipo_deserializer_pkg::*;
#(
   parameter int unsigned N = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         push,
   input  logic [N-1:0] push_data,
   input  logic         out_ready,
   input  logic         clr_ovr,
   output logic [N-1:0] out_data,
   output logic         out_valid,
   output logic         overrun
);

   logic drop;

   // A completed word is dropped only when the held word is not being consumed.
   assign drop = push && out_valid && !out_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_data  <= '0;
         out_valid <= 1'b0;
      end else if (push) begin
         if (!out_valid || out_ready) begin
            out_data  <= push_data;
            out_valid <= 1'b1;
         end
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overrun <= 1'b0;
      end else if (drop) begin
         overrun <= 1'b1;
      end else if (clr_ovr) begin
         overrun <= 1'b0;
      end
   end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-to-parallel receiver: strobed bit collection, framing and word hand-off.
module sipo_deserializer
   import sipo_deserializer_pkg::*;
#(
   parameter int unsigned N         = 8,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         ser_in,
   input  logic         ser_valid,
   input  logic         frame_start,
   output logic [N-1:0] out_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         overrun,
   input  logic         clr_ovr,
   output logic         busy
);

   localparam int unsigned CW = cnt_width(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   state_t        state;
   logic [CW-1:0] bit_cnt;
   logic [N-1:0]  sh;
   logic [N-1:0]  sh_base;
   logic [N-1:0]  sh_next;
   logic          complete;

   // frame_start discards the partial word, so the new bit shifts into a clean register.
   always_comb begin
      sh_base = frame_start ? '0 : sh;
      if (MSB_FIRST) begin
         sh_next = {sh_base[N-2:0], ser_in};
      end else begin
         sh_next = {ser_in, sh_base[N-1:1]};
      end
   end

   assign complete = ser_valid && !frame_start && (bit_cnt == LAST);
   assign busy     = (state == SHIFT);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sh      <= '0;
         bit_cnt <= '0;
         state   <= IDLE;
      end else if (ser_valid) begin
         sh <= sh_next;
         if (frame_start) begin
            bit_cnt <= CW'(1);
            state   <= SHIFT;
         end else if (complete) begin
            bit_cnt <= '0;
            state   <= IDLE;
         end else begin
            bit_cnt <= bit_cnt + CW'(1);
            state   <= SHIFT;
         end
      end else if (frame_start) begin
         sh      <= '0;
         bit_cnt <= '0;
         state   <= IDLE;
      end
   end

   sipo_out_buf #(
      .N (N)
   ) u_out_buf (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (complete),
      .push_data (sh_next),
      .out_ready (out_ready),
      .clr_ovr   (clr_ovr),
      .out_data  (out_data),
      .out_valid (out_valid),
      .overrun   (overrun)
   );

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed self-checking bench for sipo_deserializer (N=8, both bit orders).
module tb_sipo_deserializer;

   logic       clk;
   logic       reset_n;
   logic       ser_in;
   logic       ser_valid;
   logic       frame_start;
   logic       out_ready;
   logic       clr_ovr;
   logic [7:0] out_data;
   logic       out_valid;
   logic       overrun;
   logic       busy;
   logic [7:0] lsb_data;
   logic       lsb_valid;
   logic       lsb_overrun;
   logic       lsb_busy;

   int errors = 0;
   int checks = 0;

   sipo_deserializer #(.N(8), .MSB_FIRST(1'b1)) dut (
      .clk(clk), .reset_n(reset_n), .ser_in(ser_in), .ser_valid(ser_valid),
      .frame_start(frame_start), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .overrun(overrun), .clr_ovr(clr_ovr), .busy(busy)
   );

   sipo_deserializer #(.N(8), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .reset_n(reset_n), .ser_in(ser_in), .ser_valid(ser_valid),
      .frame_start(frame_start), .out_data(lsb_data), .out_valid(lsb_valid),
      .out_ready(out_ready), .overrun(lsb_overrun), .clr_ovr(clr_ovr), .busy(lsb_busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [7:0] w);
      for (int i = 7; i >= 0; i--) begin
         ser_in    = w[i];
         ser_valid = 1'b1;
         tick();
      end
      ser_valid = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      clr_ovr   = 1'b1;
      tick();
      clr_ovr   = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; ser_in = 1'b0; ser_valid = 1'b0; frame_start = 1'b0;
      out_ready = 1'b1; clr_ovr = 1'b0;
      #22;
      checks++;
      if ({out_data, out_valid, overrun, busy} !== 11'h000) begin
         errors++;
         $display("FAIL reset_state: got data=%h v=%b o=%b b=%b expected all 0", out_data, out_valid, overrun, busy);
      end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_msb_lsb();
      send_word(8'hC1);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'hC1) begin
         errors++;
         $display("FAIL msb_word: got v=%b data=%h expected v=1 data=c1", out_valid, out_data);
      end
      checks++;
      if (lsb_valid !== 1'b1 || lsb_data !== 8'h83) begin
         errors++;
         $display("FAIL lsb_word: got v=%b data=%h expected v=1 data=83", lsb_valid, lsb_data);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL valid_one_cycle: got v=%b expected 0", out_valid);
      end
   endtask

   task automatic test_gapped();
      logic [7:0] w;
      w = 8'hA5;
      for (int i = 7; i >= 0; i--) begin
         ser_in    = w[i];
         ser_valid = 1'b1;
         tick();
         ser_valid = 1'b0;
         if (i > 0) begin
            checks++;
            if (busy !== 1'b1) begin
               errors++;
               $display("FAIL busy_mid_word: got %b expected 1 at bit index %0d", busy, 7 - i);
            end
         end
         if (i == 4) begin
            for (int g = 0; g < 3; g++) tick();
            checks++;
            if (busy !== 1'b1 || out_valid !== 1'b0) begin
               errors++;
               $display("FAIL gap_hold: got busy=%b v=%b expected busy=1 v=0", busy, out_valid);
            end
         end
      end
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'hA5) begin
         errors++;
         $display("FAIL gapped_word: got busy=%b v=%b data=%h expected busy=0 v=1 data=a5", busy, out_valid, out_data);
      end
      drain();
   endtask

   task automatic test_overrun();
      out_ready = 1'b0;
      send_word(8'h11);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h11 || overrun !== 1'b0) begin
         errors++;
         $display("FAIL ovr_first: got v=%b data=%h o=%b expected v=1 data=11 o=0", out_valid, out_data, overrun);
      end
      send_word(8'h22);
      checks++;
      if (out_data !== 8'h11 || overrun !== 1'b1) begin
         errors++;
         $display("FAIL ovr_drop: got data=%h o=%b expected data=11 o=1", out_data, overrun);
      end
      clr_ovr = 1'b1;
      tick();
      clr_ovr = 1'b0;
      checks++;
      if (overrun !== 1'b0) begin
         errors++;
         $display("FAIL ovr_clear: got o=%b expected 0", overrun);
      end
      for (int i = 7; i >= 0; i--) begin
         ser_in    = i[0];
         ser_valid = 1'b1;
         clr_ovr   = (i == 0);
         tick();
      end
      ser_valid = 1'b0;
      clr_ovr   = 1'b0;
      checks++;
      if (overrun !== 1'b1 || out_data !== 8'h11) begin
         errors++;
         $display("FAIL ovr_set_priority: got o=%b data=%h expected o=1 data=11", overrun, out_data);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      logic [7:0] w;
      out_ready = 1'b0;
      send_word(8'h3C);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h3C) begin
         errors++;
         $display("FAIL b2b_first: got v=%b data=%h expected v=1 data=3c", out_valid, out_data);
      end
      w = 8'h5A;
      for (int i = 7; i >= 0; i--) begin
         ser_in    = w[i];
         ser_valid = 1'b1;
         out_ready = (i == 0);
         tick();
      end
      ser_valid = 1'b0;
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h5A || overrun !== 1'b0) begin
         errors++;
         $display("FAIL b2b_second: got v=%b data=%h o=%b expected v=1 data=5a o=0", out_valid, out_data, overrun);
      end
      drain();
   endtask

   task automatic test_frame_start();
      logic [7:0] w;
      w = 8'hF0;
      send_word(8'h00);
      drain();
      for (int i = 0; i < 5; i++) begin
         ser_in    = i[0];
         ser_valid = 1'b1;
         tick();
      end
      for (int i = 7; i >= 0; i--) begin
         ser_in      = w[i];
         ser_valid   = 1'b1;
         frame_start = (i == 7);
         tick();
      end
      ser_valid   = 1'b0;
      frame_start = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'hF0) begin
         errors++;
         $display("FAIL frame_realign: got v=%b data=%h expected v=1 data=f0", out_valid, out_data);
      end
      drain();
      for (int i = 0; i < 3; i++) begin
         ser_in    = 1'b1;
         ser_valid = 1'b1;
         tick();
      end
      ser_valid   = 1'b0;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL frame_abort_busy: got %b expected 0", busy);
      end
      send_word(8'h96);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h96) begin
         errors++;
         $display("FAIL frame_abort_word: got v=%b data=%h expected v=1 data=96", out_valid, out_data);
      end
      drain();
   endtask

   task automatic test_reset_mid_word();
      out_ready = 1'b0;
      send_word(8'h11);
      send_word(8'h22);
      for (int i = 0; i < 3; i++) begin
         ser_in    = 1'b1;
         ser_valid = 1'b1;
         tick();
      end
      ser_valid = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({out_data, out_valid, overrun, busy} !== 11'h000) begin
         errors++;
         $display("FAIL async_reset: got data=%h v=%b o=%b b=%b expected all 0", out_data, out_valid, overrun, busy);
      end
      #1 reset_n = 1'b1;
      out_ready = 1'b1;
      tick();
      send_word(8'h69);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h69 || overrun !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_word: got v=%b data=%h o=%b expected v=1 data=69 o=0", out_valid, out_data, overrun);
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_msb_lsb();
      test_gapped();
      test_overrun();
      test_back_to_back();
      test_frame_start();
      test_reset_mid_word();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
